// File: rtl/chess_pkg.sv
// chess_pkg: piece codes, colours, start position and controller state encoding
// shared by the board/move controller.
package chess_pkg;

  localparam logic [2:0] NONE   = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  // Square i lives in bits [i*4+3:i*4]; each 32-bit group below is one row,
  // written with col 7 on the left. Row 7 (white back rank) is the MSB group.
  localparam logic [255:0] INIT_BOARD = {
    32'h4236_5324,   // row 7: white R N B Q K B N R
    32'h1111_1111,   // row 6: white pawns
    128'h0,          // rows 5..2: empty
    32'h9999_9999,   // row 1: black pawns
    32'hCABE_DBAC    // row 0: black R N B Q K B N R
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    COMMIT   = 2'd2,
    OVER     = 2'd3
  } state_e;

  // Fetch the 4-bit nibble of one square.
  function automatic logic [3:0] sq_get(input logic [255:0] board, input logic [5:0] addr);
    return board[{addr, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// btn_edge_detect: registers the debounced button levels and flags rising edges.
// A level that is already high when the history is cleared reads as a fresh press.
module btn_edge_detect #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] btn,
  output logic [W-1:0] press
);

  logic [W-1:0] btn_q;
  logic [W-1:0] btn_d;

  // History simply follows the inputs every clock.
  always_comb begin
    btn_d = btn;
  end

  // Button history register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) btn_q <= '0;
    else       btn_q <= btn_d;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/board_move_ctrl.sv
// board_move_ctrl: owns the board register, cursor and selection; turns button
// presses into moves that are committed only during vertical blanking.
// Optional build macro PROMOTION_EN: a pawn reaching the far rank is written as a queen.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no selection; C selects an own piece under the cursor
// SELECTED | source held; C deselects, reselects, or picks a target
// COMMIT   | target latched; waits for VBLANK, then writes the move
// OVER     | a king was captured; frozen until RESET
module board_move_ctrl
  import chess_pkg::*;
#(
  parameter logic [5:0] CURSOR_INIT = 6'd52,
  parameter int         BTN_W       = 5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         BTN_C,
  input  logic         BTN_U,
  input  logic         BTN_D,
  input  logic         BTN_L,
  input  logic         BTN_R,
  input  logic         VBLANK,
  output logic [255:0] BOARD,
  output logic [5:0]   CURSOR_ADDR,
  output logic [5:0]   SELECT_ADDR,
  output logic         SELECT_EN,
  output logic         TURN,
  output logic         MOVE_DONE,
  output logic         GAME_OVER
);

  // Bit order: [0]=C (highest priority) .. [4]=R (lowest).
  logic [BTN_W-1:0] btn;
  logic [BTN_W-1:0] press;

  assign btn = {BTN_R, BTN_L, BTN_D, BTN_U, BTN_C};

  btn_edge_detect #(.W(BTN_W)) u_btn_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .btn   (btn),
    .press (press)
  );

  state_e         state_q, state_d;
  logic [255:0]   board_q, board_d;
  logic [5:0]     cursor_q, cursor_d;
  logic [5:0]     sel_addr_q, sel_addr_d;
  logic           sel_en_q, sel_en_d;
  logic [5:0]     dst_q, dst_d;
  logic           turn_q, turn_d;
  logic           move_done_q, move_done_d;
  logic           game_over_q, game_over_d;

  logic [3:0]     cur_pc, src_pc, dst_pc, wr_pc;
  logic [2:0]     row, col;
  logic           cur_own;

  // Next-state, cursor, selection and board-write logic.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    cursor_d    = cursor_q;
    sel_addr_d  = sel_addr_q;
    sel_en_d    = sel_en_q;
    dst_d       = dst_q;
    turn_d      = turn_q;
    move_done_d = 1'b0;
    game_over_d = game_over_q;

    cur_pc  = sq_get(board_q, cursor_q);
    src_pc  = sq_get(board_q, sel_addr_q);
    dst_pc  = sq_get(board_q, dst_q);
    cur_own = (cur_pc[2:0] != NONE) && (cur_pc[3] == turn_q);
    row     = cursor_q[5:3];
    col     = cursor_q[2:0];

    wr_pc = src_pc;
`ifdef PROMOTION_EN
    if (src_pc[2:0] == PAWN &&
        ((src_pc[3] == COLOR_WHITE && dst_q[5:3] == 3'd0) ||
         (src_pc[3] == COLOR_BLACK && dst_q[5:3] == 3'd7)))
      wr_pc = {src_pc[3], QUEEN};
`endif

    case (state_q)
      IDLE, SELECTED: begin
        if (press[0]) begin
          if (state_q == IDLE) begin
            if (cur_own) begin
              sel_addr_d = cursor_q;
              sel_en_d   = 1'b1;
              state_d    = SELECTED;
            end
          end else if (cursor_q == sel_addr_q) begin
            sel_en_d = 1'b0;
            state_d  = IDLE;
          end else if (cur_own) begin
            sel_addr_d = cursor_q;
          end else begin
            dst_d   = cursor_q;
            state_d = COMMIT;
          end
        end else if (press[1]) begin
          cursor_d = {row - 3'd1, col};
        end else if (press[2]) begin
          cursor_d = {row + 3'd1, col};
        end else if (press[3]) begin
          cursor_d = {row, col - 3'd1};
        end else if (press[4]) begin
          cursor_d = {row, col + 3'd1};
        end
      end
      COMMIT: begin
        if (VBLANK) begin
          board_d[{dst_q, 2'b00} +: 4]      = wr_pc;
          board_d[{sel_addr_q, 2'b00} +: 4] = 4'b0000;
          sel_en_d    = 1'b0;
          turn_d      = ~turn_q;
          move_done_d = 1'b1;
          if (dst_pc[2:0] == KING) begin
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            state_d = IDLE;
          end
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset restores the start position.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      board_q     <= INIT_BOARD;
      cursor_q    <= CURSOR_INIT;
      sel_addr_q  <= 6'd0;
      sel_en_q    <= 1'b0;
      dst_q       <= 6'd0;
      turn_q      <= COLOR_WHITE;
      move_done_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      cursor_q    <= cursor_d;
      sel_addr_q  <= sel_addr_d;
      sel_en_q    <= sel_en_d;
      dst_q       <= dst_d;
      turn_q      <= turn_d;
      move_done_q <= move_done_d;
      game_over_q <= game_over_d;
    end
  end

  assign BOARD       = board_q;
  assign CURSOR_ADDR = cursor_q;
  assign SELECT_ADDR = sel_addr_q;
  assign SELECT_EN   = sel_en_q;
  assign TURN        = turn_q;
  assign MOVE_DONE   = move_done_q;
  assign GAME_OVER   = game_over_q;

endmodule

// File: tb/tb_board_move_ctrl.sv
// tb_board_move_ctrl: scenario tasks with inline checks; cursor/selection
// expectations and committed moves flow through scoreboard queues.
module tb_board_move_ctrl;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic BTN_C = 1'b0, BTN_U = 1'b0, BTN_D = 1'b0, BTN_L = 1'b0, BTN_R = 1'b0;
  logic VBLANK = 1'b0;
  logic [255:0] BOARD;
  logic [5:0]   CURSOR_ADDR, SELECT_ADDR;
  logic         SELECT_EN, TURN, MOVE_DONE, GAME_OVER;

  int checks = 0;
  int failures = 0;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_C    = 5'b10000;
  localparam logic [4:0] B_U    = 5'b01000;
  localparam logic [4:0] B_D    = 5'b00100;
  localparam logic [4:0] B_L    = 5'b00010;
  localparam logic [4:0] B_R    = 5'b00001;

  localparam logic [255:0] START_POS = {32'h42365324, 32'h11111111, 128'h0,
                                        32'h99999999, 32'hCABEDBAC};
`ifdef PROMOTION_EN
  localparam logic [3:0] PROMO_W = 4'b0101;
`else
  localparam logic [3:0] PROMO_W = 4'b0001;
`endif

  typedef struct {
    logic [5:0] cur;
    logic       sel_en;
    logic [5:0] sel;
  } cur_t;

  typedef struct {
    int         src;
    int         dst;
    logic [3:0] piece;
    logic       king;
  } mv_t;

  cur_t cur_q[$];
  mv_t  mv_q[$];
  logic [255:0] m_board;

  board_move_ctrl dut (
    .CLK(CLK), .RESET(RESET),
    .BTN_C(BTN_C), .BTN_U(BTN_U), .BTN_D(BTN_D), .BTN_L(BTN_L), .BTN_R(BTN_R),
    .VBLANK(VBLANK),
    .BOARD(BOARD), .CURSOR_ADDR(CURSOR_ADDR), .SELECT_ADDR(SELECT_ADDR),
    .SELECT_EN(SELECT_EN), .TURN(TURN), .MOVE_DONE(MOVE_DONE), .GAME_OVER(GAME_OVER)
  );

  always #5 CLK = ~CLK;

  task automatic set_btns(input logic [4:0] m);
    {BTN_C, BTN_U, BTN_D, BTN_L, BTN_R} = m;
  endtask

  // Release everything for one edge, then press; returns 1 time unit after the acting edge.
  task automatic drive_press(input logic [4:0] m);
    @(negedge CLK); set_btns(B_NONE);
    @(negedge CLK); set_btns(m);
    @(posedge CLK); #1;
  endtask

  task automatic wait_move(input int bound, output int cyc);
    set_btns(B_NONE);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge CLK); #1;
      if (MOVE_DONE === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    #1;
    checks++;
    if (BOARD[211:208] !== 4'b0001) begin failures++; $display("FAIL reset_sq52: got %b want 0001", BOARD[211:208]); end
    checks++;
    if (BOARD[3:0] !== 4'b1100) begin failures++; $display("FAIL reset_sq0: got %b want 1100", BOARD[3:0]); end
    checks++;
    if (BOARD !== START_POS) begin failures++; $display("FAIL reset_board: got %h want %h", BOARD, START_POS); end
    checks++;
    if (CURSOR_ADDR !== 6'd52 || TURN !== 1'b0 || SELECT_EN !== 1'b0 || SELECT_ADDR !== 6'd0 ||
        MOVE_DONE !== 1'b0 || GAME_OVER !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: cur=%0d turn=%b sel_en=%b sel=%0d done=%b over=%b want 52 0 0 0 0 0",
               CURSOR_ADDR, TURN, SELECT_EN, SELECT_ADDR, MOVE_DONE, GAME_OVER);
    end
    @(negedge CLK); RESET = 1'b0;
    m_board = START_POS;
  endtask

  task automatic test_cursor_wrap();
    logic [4:0] seq   [16] = '{B_L, B_L, B_L, B_L, B_L, B_U, B_U, B_U, B_U, B_U, B_U, B_U,
                               B_U, B_L, B_L, B_L};
    logic [5:0] exp_c [16] = '{6'd51, 6'd50, 6'd49, 6'd48, 6'd55, 6'd47, 6'd39, 6'd31,
                               6'd23, 6'd15, 6'd7, 6'd63, 6'd55, 6'd54, 6'd53, 6'd52};
    cur_t e;
    for (int i = 0; i < 16; i++) begin
      cur_q.push_back('{exp_c[i], 1'b0, 6'd0});
      drive_press(seq[i]);
      e = cur_q.pop_front();
      checks++;
      if (CURSOR_ADDR !== e.cur || SELECT_EN !== e.sel_en) begin
        failures++;
        $display("FAIL cursor_wrap[%0d]: cur=%0d sel_en=%b want cur=%0d sel_en=%b",
                 i, CURSOR_ADDR, SELECT_EN, e.cur, e.sel_en);
      end
    end
  endtask

  task automatic test_select_move();
    logic [4:0] seq [4] = '{B_C, B_U, B_U, B_C};
    cur_t       ex  [4] = '{'{6'd52, 1'b1, 6'd52}, '{6'd44, 1'b1, 6'd52},
                            '{6'd36, 1'b1, 6'd52}, '{6'd36, 1'b1, 6'd52}};
    cur_t e;
    mv_t  mv;
    int   bad;
    int   cyc;
    for (int i = 0; i < 4; i++) begin
      cur_q.push_back(ex[i]);
      if (i == 3) mv_q.push_back('{52, 36, 4'b0001, 1'b0});
      drive_press(seq[i]);
      e = cur_q.pop_front();
      checks++;
      if (CURSOR_ADDR !== e.cur || SELECT_EN !== e.sel_en || SELECT_ADDR !== e.sel) begin
        failures++;
        $display("FAIL select_move[%0d]: cur=%0d sel_en=%b sel=%0d want %0d %b %0d",
                 i, CURSOR_ADDR, SELECT_EN, SELECT_ADDR, e.cur, e.sel_en, e.sel);
      end
    end
    set_btns(B_NONE);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge CLK); #1;
      if (MOVE_DONE !== 1'b0 || BOARD !== m_board) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL commit_hold: %0d cycles changed, want 0", bad); end
    @(negedge CLK); VBLANK = 1'b1;
    wait_move(20, cyc);
    checks++;
    if (cyc !== 1) begin failures++; $display("FAIL commit_latency: got %0d want 1", cyc); end
    checks++;
    if (mv_q.size() == 0) begin
      failures++; $display("FAIL move_sb: got empty queue want 1 entry");
    end else begin
      mv = mv_q.pop_front();
      m_board[mv.dst*4 +: 4] = mv.piece;
      m_board[mv.src*4 +: 4] = 4'b0000;
      if (BOARD !== m_board || TURN !== 1'b1 || SELECT_EN !== 1'b0 || GAME_OVER !== mv.king) begin
        failures++;
        $display("FAIL move1: sq36=%b sq52=%b turn=%b sel_en=%b over=%b want 0001 0000 1 0 %b",
                 BOARD[147:144], BOARD[211:208], TURN, SELECT_EN, GAME_OVER, mv.king);
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (MOVE_DONE !== 1'b0) begin failures++; $display("FAIL move_done_pulse: got %b want 0", MOVE_DONE); end
    @(negedge CLK); VBLANK = 1'b0;
  endtask

  task automatic test_illegal_select();
    logic [4:0] seq [9] = '{B_C, B_C | B_U, B_U, B_U, B_U, B_C | B_U, B_L, B_C, B_C};
    cur_t       ex  [9] = '{'{6'd36, 1'b0, 6'd0}, '{6'd36, 1'b0, 6'd0}, '{6'd28, 1'b0, 6'd0},
                            '{6'd20, 1'b0, 6'd0}, '{6'd12, 1'b0, 6'd0}, '{6'd12, 1'b1, 6'd12},
                            '{6'd11, 1'b1, 6'd12}, '{6'd11, 1'b1, 6'd11}, '{6'd11, 1'b0, 6'd0}};
    cur_t e;
    for (int i = 0; i < 9; i++) begin
      cur_q.push_back(ex[i]);
      drive_press(seq[i]);
      e = cur_q.pop_front();
      checks++;
      if (CURSOR_ADDR !== e.cur || SELECT_EN !== e.sel_en ||
          (e.sel_en && SELECT_ADDR !== e.sel)) begin
        failures++;
        $display("FAIL illegal_select[%0d]: cur=%0d sel_en=%b sel=%0d want %0d %b %0d",
                 i, CURSOR_ADDR, SELECT_EN, SELECT_ADDR, e.cur, e.sel_en, e.sel);
      end
    end
    checks++;
    if (TURN !== 1'b1 || BOARD !== m_board) begin
      failures++; $display("FAIL illegal_side_effects: turn=%b board_changed=%b want 1 0", TURN, BOARD !== m_board);
    end
  endtask

  task automatic test_king_capture();
    logic [4:0] seq1 [3]  = '{B_C, B_D, B_C};
    cur_t       ex1  [3]  = '{'{6'd11, 1'b1, 6'd11}, '{6'd19, 1'b1, 6'd11}, '{6'd19, 1'b1, 6'd11}};
    logic [4:0] seq2 [9]  = '{B_D, B_D, B_R, B_C, B_U, B_U, B_U, B_U, B_C};
    cur_t       ex2  [9]  = '{'{6'd27, 1'b0, 6'd0}, '{6'd35, 1'b0, 6'd0}, '{6'd36, 1'b0, 6'd0},
                              '{6'd36, 1'b1, 6'd36}, '{6'd28, 1'b1, 6'd36}, '{6'd20, 1'b1, 6'd36},
                              '{6'd12, 1'b1, 6'd36}, '{6'd4, 1'b1, 6'd36}, '{6'd4, 1'b1, 6'd36}};
    logic [4:0] seq3 [5]  = '{B_U, B_C, B_L, B_R, B_D};
    cur_t e;
    mv_t  mv;
    int   cyc;
    // Black move with VBLANK already high: commit lands one edge after entry.
    @(negedge CLK); VBLANK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cur_q.push_back(ex1[i]);
      if (i == 2) mv_q.push_back('{11, 19, 4'b1001, 1'b0});
      drive_press(seq1[i]);
      e = cur_q.pop_front();
      checks++;
      if (CURSOR_ADDR !== e.cur || SELECT_EN !== e.sel_en || SELECT_ADDR !== e.sel) begin
        failures++;
        $display("FAIL black_move[%0d]: cur=%0d sel_en=%b sel=%0d want %0d %b %0d",
                 i, CURSOR_ADDR, SELECT_EN, SELECT_ADDR, e.cur, e.sel_en, e.sel);
      end
    end
    wait_move(20, cyc);
    checks++;
    if (cyc !== 1) begin failures++; $display("FAIL vblank_on_entry: got %0d cycles want 1", cyc); end
    checks++;
    if (mv_q.size() == 0) begin
      failures++; $display("FAIL move_sb: got empty queue want 1 entry");
    end else begin
      mv = mv_q.pop_front();
      m_board[mv.dst*4 +: 4] = mv.piece;
      m_board[mv.src*4 +: 4] = 4'b0000;
      if (BOARD !== m_board || TURN !== 1'b0 || GAME_OVER !== mv.king) begin
        failures++;
        $display("FAIL black_commit: sq19=%b sq11=%b turn=%b over=%b want 1001 0000 0 0",
                 BOARD[79:76], BOARD[47:44], TURN, GAME_OVER);
      end
    end
    @(negedge CLK); VBLANK = 1'b0;
    // White pawn takes the black king on row 0.
    for (int i = 0; i < 9; i++) begin
      cur_q.push_back(ex2[i]);
      if (i == 8) mv_q.push_back('{36, 4, PROMO_W, 1'b1});
      drive_press(seq2[i]);
      e = cur_q.pop_front();
      checks++;
      if (CURSOR_ADDR !== e.cur || SELECT_EN !== e.sel_en || (e.sel_en && SELECT_ADDR !== e.sel)) begin
        failures++;
        $display("FAIL white_move[%0d]: cur=%0d sel_en=%b sel=%0d want %0d %b %0d",
                 i, CURSOR_ADDR, SELECT_EN, SELECT_ADDR, e.cur, e.sel_en, e.sel);
      end
    end
    @(negedge CLK); VBLANK = 1'b1;
    wait_move(20, cyc);
    checks++;
    if (cyc !== 1) begin failures++; $display("FAIL capture_latency: got %0d want 1", cyc); end
    checks++;
    if (mv_q.size() == 0) begin
      failures++; $display("FAIL move_sb: got empty queue want 1 entry");
    end else begin
      mv = mv_q.pop_front();
      m_board[mv.dst*4 +: 4] = mv.piece;
      m_board[mv.src*4 +: 4] = 4'b0000;
      if (BOARD !== m_board || GAME_OVER !== mv.king || TURN !== 1'b1 || SELECT_EN !== 1'b0) begin
        failures++;
        $display("FAIL king_capture: sq4=%b sq36=%b over=%b turn=%b sel_en=%b want %b 0000 1 1 0",
                 BOARD[19:16], BOARD[147:144], GAME_OVER, TURN, SELECT_EN, PROMO_W);
      end
    end
    checks++;
    if (BOARD[19:16] !== PROMO_W) begin failures++; $display("FAIL promotion_nibble: got %b want %b", BOARD[19:16], PROMO_W); end
    for (int i = 0; i < 5; i++) begin
      drive_press(seq3[i]);
      checks++;
      if (CURSOR_ADDR !== 6'd4 || BOARD !== m_board || MOVE_DONE !== 1'b0 || GAME_OVER !== 1'b1) begin
        failures++;
        $display("FAIL over_frozen[%0d]: cur=%0d board_changed=%b done=%b over=%b want 4 0 0 1",
                 i, CURSOR_ADDR, BOARD !== m_board, MOVE_DONE, GAME_OVER);
      end
    end
  endtask

  task automatic test_reset_mid_commit();
    logic [4:0] seq [3] = '{B_C, B_U, B_C};
    logic [5:0] exc [3] = '{6'd52, 6'd44, 6'd44};
    @(negedge CLK); RESET = 1'b1; VBLANK = 1'b0; set_btns(B_NONE);
    @(negedge CLK); RESET = 1'b0;
    m_board = START_POS;
    #1;
    checks++;
    if (GAME_OVER !== 1'b0 || BOARD !== m_board) begin
      failures++; $display("FAIL reset_from_over: over=%b board_changed=%b want 0 0", GAME_OVER, BOARD !== m_board);
    end
    for (int i = 0; i < 3; i++) begin
      cur_q.push_back('{exc[i], 1'b1, 6'd52});
      drive_press(seq[i]);
      checks++;
      if (CURSOR_ADDR !== cur_q[0].cur || SELECT_EN !== cur_q[0].sel_en || SELECT_ADDR !== cur_q[0].sel) begin
        failures++;
        $display("FAIL pre_commit[%0d]: cur=%0d sel_en=%b sel=%0d want %0d 1 52",
                 i, CURSOR_ADDR, SELECT_EN, SELECT_ADDR, cur_q[0].cur);
      end
      void'(cur_q.pop_front());
    end
    set_btns(B_NONE);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RESET = 1'b1; set_btns(B_U);
    #1;
    checks++;
    if (BOARD !== START_POS || CURSOR_ADDR !== 6'd52 || SELECT_EN !== 1'b0 || TURN !== 1'b0 ||
        MOVE_DONE !== 1'b0 || GAME_OVER !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_commit: board_changed=%b cur=%0d sel_en=%b turn=%b want 0 52 0 0",
               BOARD !== START_POS, CURSOR_ADDR, SELECT_EN, TURN);
    end
    @(negedge CLK); RESET = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (CURSOR_ADDR !== 6'd44) begin failures++; $display("FAIL held_through_reset: cur=%0d want 44", CURSOR_ADDR); end
    @(negedge CLK); VBLANK = 1'b1; set_btns(B_NONE);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (BOARD !== START_POS || MOVE_DONE !== 1'b0 || TURN !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: board_changed=%b done=%b turn=%b want 0 0 0",
                           BOARD !== START_POS, MOVE_DONE, TURN);
    end
    VBLANK = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cursor_wrap();
    test_select_move();
    test_illegal_select();
    test_king_capture();
    test_reset_mid_commit();
    checks++;
    if (mv_q.size() != 0) begin failures++; $display("FAIL move_sb_leftover: got %0d entries want 0", mv_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
